// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_tx
//  Description : I2S master transmitter. Right-justified PCM words are
//                written into an internal FIFO. The block generates sck/ws
//                and shifts each word out MSB-first on sdo. Frame timing
//                matches the companion receiver, so both can share one
//                prescaler setting. An empty FIFO at the start of an
//                enabled slot raises a one-clock underflow pulse.
//  Ports       : clk, rst_n (async, active-low), en,
//                sck_prescaler (sck half-period = value+1 clk),
//                sample_size (0 = 32), left_justified, channels {L,R},
//                fifo_wr / fifo_wdata / fifo_level_threshold,
//                fifo_full / fifo_empty / fifo_level / fifo_level_below,
//                underflow, sck / ws / sdo (ws 0 = left, 1 = right)
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [7:0]    sck_prescaler,
    input  logic [4:0]    sample_size,
    input  logic          left_justified,
    input  logic [1:0]    channels,
    input  logic          fifo_wr,
    input  logic [31:0]   fifo_wdata,
    input  logic [AW:0]   fifo_level_threshold,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   fifo_level,
    output logic          fifo_level_below,
    output logic          underflow,
    output logic          sck,
    output logic          ws,
    output logic          sdo
);

    localparam int          c_DEPTH     = 2 ** AW;
    localparam logic [AW:0] c_LEVEL_MAX = c_DEPTH[AW:0];
    localparam logic [AW:0] c_LEVEL_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] c_PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Bus timing state
    // ------------------------------------------------------------------
    logic [7:0]  r_presc;
    logic        r_sck;
    logic        r_ws;
    logic        r_sdo;
    logic [4:0]  r_bit_ctr;
    logic [31:0] r_shreg;
    logic        r_underflow;

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [31:0]   r_mem [c_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic        w_fall;
    logic        w_slot;
    logic        w_ch_en;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wr;
    logic [31:0] w_rdata;
    logic [4:0]  w_shamt;
    logic [31:0] w_word;

    // Fall event: the clk in which sck goes 1->0. A slot starts on the fall
    // that wraps the bit counter.
    assign w_fall  = en & (r_presc == 8'd0) & r_sck;
    assign w_slot  = w_fall & (r_bit_ctr == 5'd0);

    // ws flips on the slot start, so the current ws=1 means the new slot is
    // the left one.
    assign w_ch_en = r_ws ? channels[1] : channels[0];

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_LEVEL_MAX);
    assign w_pop   = w_slot & w_ch_en & ~w_empty;
    assign w_wr    = fifo_wr & ~w_full;

    // Show-ahead read; left-align the N valid bits. 32-N modulo 32 is the
    // two's complement of sample_size, which also maps the 0 (=32) code to
    // a zero shift.
    assign w_rdata = r_mem[r_rd_ptr];
    assign w_shamt = 5'd0 - sample_size;
    assign w_word  = w_pop ? (w_rdata << w_shamt) : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc     <= sck_prescaler;
            r_sck       <= 1'b0;
            r_ws        <= 1'b1;
            r_sdo       <= 1'b0;
            r_bit_ctr   <= 5'd0;
            r_shreg     <= 32'd0;
            r_underflow <= 1'b0;
        end else if (!en) begin
            // Parked: next enable begins with a fresh half-period and a
            // left slot; any partially sent word is discarded.
            r_presc     <= sck_prescaler;
            r_sck       <= 1'b0;
            r_ws        <= 1'b1;
            r_sdo       <= 1'b0;
            r_bit_ctr   <= 5'd0;
            r_shreg     <= 32'd0;
            r_underflow <= 1'b0;
        end else begin
            if (r_presc == 8'd0) begin
                r_presc <= sck_prescaler;
                r_sck   <= ~r_sck;
            end else begin
                r_presc <= r_presc - 8'd1;
            end

            r_underflow <= w_slot & w_ch_en & w_empty;

            if (w_fall) begin
                r_bit_ctr <= r_bit_ctr + 5'd1;
                if (w_slot) begin
                    r_ws <= ~r_ws;
                    if (left_justified) begin
                        r_sdo   <= w_word[31];
                        r_shreg <= {w_word[30:0], 1'b0};
                    end else begin
                        // I2S: the previous word's LSB goes out in the
                        // first bit time of the new slot.
                        r_sdo   <= r_shreg[31];
                        r_shreg <= w_word;
                    end
                end else begin
                    r_sdo   <= r_shreg[31];
                    r_shreg <= {r_shreg[30:0], 1'b0};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= fifo_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + c_LEVEL_ONE;
                2'b01:   r_level <= r_level - c_LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    assign fifo_full        = w_full;
    assign fifo_empty       = w_empty;
    assign fifo_level       = r_level;
    assign fifo_level_below = (r_level < fifo_level_threshold);
    assign underflow        = r_underflow;
    assign sck              = r_sck;
    assign ws               = r_ws;
    assign sdo              = r_sdo;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2s_tx
//  Description : Scoreboard bench for i2s_tx. A reference model turns FIFO
//                contents and slot configuration into the expected stream
//                of (ws, sdo) pairs seen at each sck rising edge; a monitor
//                pops and compares them as the bus produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_tx;

    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [7:0]    sck_prescaler = 8'd1;
    logic [4:0]    sample_size = 5'd0;
    logic          left_justified = 1'b0;
    logic [1:0]    channels = 2'b11;
    logic          fifo_wr = 1'b0;
    logic [31:0]   fifo_wdata = 32'd0;
    logic [AW:0]   fifo_level_threshold = 5'd8;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW:0]   fifo_level;
    logic          fifo_level_below;
    logic          underflow;
    logic          sck;
    logic          ws;
    logic          sdo;

    i2s_tx #(.AW(AW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .en                   (en),
        .sck_prescaler        (sck_prescaler),
        .sample_size          (sample_size),
        .left_justified       (left_justified),
        .channels             (channels),
        .fifo_wr              (fifo_wr),
        .fifo_wdata           (fifo_wdata),
        .fifo_level_threshold (fifo_level_threshold),
        .fifo_full            (fifo_full),
        .fifo_empty           (fifo_empty),
        .fifo_level           (fifo_level),
        .fifo_level_below     (fifo_level_below),
        .underflow            (underflow),
        .sck                  (sck),
        .ws                   (ws),
        .sdo                  (sdo)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  exp_q [$];   // {ws, sdo} expected at each sck rise
    logic [31:0] mq [$];      // model of FIFO contents
    int          uf_seen = 0;
    int          exp_period = 4;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares each sck rise against the scoreboard and checks
    // the sck period between consecutive rises of the same run.
    // ------------------------------------------------------------------
    logic prev_sck = 1'b0;
    int   cyc = 0;
    int   last_rise = -1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (underflow === 1'b1) uf_seen++;
            if (!en) last_rise = -1;
            if (sck && !prev_sck) begin
                if (exp_q.size() > 0) begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    chk("ws_sdo", {62'd0, ws, sdo}, {62'd0, e});
                    if (last_rise >= 0) chk("sck_period", 64'(cyc - last_rise), 64'(exp_period));
                    last_rise = cyc;
                end else begin
                    last_rise = -1;
                end
            end
            prev_sck = sck;
        end
    end

    task automatic wr_word(input logic [31:0] d);
        @(negedge clk);
        fifo_wr    = 1'b1;
        fifo_wdata = d;
        if (mq.size() < DEPTH) mq.push_back(d);
        @(negedge clk);
        fifo_wr    = 1'b0;
    endtask

    // Builds the expected bus stream for nslots slots from the model FIFO,
    // then enables the transmitter and waits for the stream to drain.
    task automatic run(input int p, input int ss, input bit lj, input bit [1:0] ch, input int nslots);
        int          n;
        int          uf_exp;
        bit          prev_lsb;
        logic [31:0] word;
        logic [31:0] d;
        bit          wsv;
        bit          ch_on;
        n        = (ss == 0) ? 32 : ss;
        uf_exp   = 0;
        prev_lsb = 1'b0;
        exp_q.delete();
        exp_q.push_back(2'b10);       // first rise precedes the first slot
        for (int s = 0; s < nslots; s++) begin
            wsv   = (s % 2) != 0;
            ch_on = wsv ? ch[0] : ch[1];
            word  = 32'd0;
            if (ch_on) begin
                if (mq.size() > 0) begin
                    d    = mq.pop_front();
                    word = d << (32 - n);
                end else begin
                    uf_exp++;
                end
            end
            if (lj) begin
                for (int b = 31; b >= 0; b--) exp_q.push_back({wsv, word[b]});
            end else begin
                exp_q.push_back({wsv, prev_lsb});
                for (int b = 31; b >= 1; b--) exp_q.push_back({wsv, word[b]});
                prev_lsb = word[0];
            end
        end
        @(negedge clk);
        sck_prescaler  = 8'(p);
        sample_size    = 5'(ss);
        left_justified = lj;
        channels       = ch;
        exp_period     = 2 * (p + 1);
        @(negedge clk);
        uf_seen = 0;
        en      = 1'b1;
        for (int t = 0; t < 64 * (p + 1) * (nslots + 2) + 100 && exp_q.size() != 0; t++)
            @(negedge clk);
        chk("stream_timeout_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        en = 1'b0;
        repeat (3) @(negedge clk);
        chk("underflow_count", 64'(uf_seen), 64'(uf_exp));
        chk("level_after_run", {59'd0, fifo_level}, 64'(mq.size()));
        chk("empty_after_run", {63'd0, fifo_empty}, {63'd0, mq.size() == 0});
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        chk("reset_sck", {63'd0, sck}, 64'd0);
        chk("reset_ws", {63'd0, ws}, 64'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_sck_ws_sdo", {61'd0, sck, ws, sdo}, {61'd0, 3'b010});
        chk("idle_empty_full", {62'd0, fifo_empty, fifo_full}, {62'd0, 2'b10});
        chk("idle_level", {59'd0, fifo_level}, 64'd0);
        chk("idle_underflow", {63'd0, underflow}, 64'd0);

        // ---------------- stereo I2S, N=32 ----------------
        wr_word(32'hA5A50001);
        wr_word(32'h80000003);
        chk("level_two", {59'd0, fifo_level}, 64'd2);
        run(1, 0, 1'b0, 2'b11, 2);

        // ---------------- left justified, N=16, left only ----------------
        wr_word(32'h00008001);
        run(2, 16, 1'b1, 2'b10, 2);

        // ---------------- underflow with empty FIFO ----------------
        run(0, 0, 1'b0, 2'b11, 4);

        // ---------------- full FIFO, dropped write, threshold ----------------
        fifo_level_threshold = 5'd8;
        for (int i = 0; i < DEPTH + 1; i++) wr_word(32'h1000_0000 + 32'(i));
        chk("full_flag", {63'd0, fifo_full}, 64'd1);
        chk("full_level", {59'd0, fifo_level}, 64'(DEPTH));
        chk("below_at_full", {63'd0, fifo_level_below}, 64'd0);
        @(negedge clk);
        fifo_wr    = 1'b1;
        fifo_wdata = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        fifo_wr    = 1'b0;
        chk("level_held_full", {59'd0, fifo_level}, 64'(DEPTH));
        fifo_level_threshold = 5'd17;
        #1;
        chk("below_thr17", {63'd0, fifo_level_below}, 64'd1);
        fifo_level_threshold = 5'd8;
        run(0, 0, 1'b0, 2'b11, 12);
        chk("below_level4", {63'd0, fifo_level_below}, 64'd1);
        run(0, 0, 1'b0, 2'b11, 4);

        // ---------------- drop en mid-slot ----------------
        wr_word(32'h12345678);
        wr_word(32'hCAFEF00D);
        @(negedge clk);
        sck_prescaler = 8'd1;
        channels      = 2'b11;
        left_justified = 1'b0;
        sample_size   = 5'd0;
        @(negedge clk);
        en = 1'b1;
        begin
            int  t;
            int  falls;
            logic ps;
            t = 0;
            while (ws !== 1'b0 && t < 200) begin @(posedge clk); #1; t++; end
            chk("ws_fall_timeout", 64'(t >= 200), 64'd0);
            falls = 0;
            ps    = sck;
            t     = 0;
            while (falls < 9 && t < 200) begin
                @(posedge clk); #1; t++;
                if (ps && !sck) falls++;
                ps = sck;
            end
            chk("falls_timeout", 64'(falls), 64'd9);
        end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_sck_ws_sdo", {61'd0, sck, ws, sdo}, {61'd0, 3'b010});
        void'(mq.pop_front());     // partially sent word is gone
        run(1, 0, 1'b0, 2'b11, 2);

        // ---------------- randomized runs ----------------
        for (int it = 0; it < 10; it++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int k = 0; k < nw; k++) wr_word($urandom);
            run($urandom_range(0, 3), $urandom_range(0, 31), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), $urandom_range(2, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
